_arbiter16: RTL and testbench

Round-robin arbiter sharing one 16-bit datapath among `N` requesters. Each requester presents a request and a 16-bit word. The block grants one requester at a time, steers that requester's word onto a single registered 16-bit output, and rotates priority so no requester starves. It sits between several producers and the shared 16-bit gate datapath (`_mux16`/`_and16`/`_or16` chain), and it is the only driver of that datapath's input.

---
 rtl/_arbiter16.sv | 167 ++++++++++++++++
 tb/tb__arbiter16.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/_arbiter16.sv
// _arbiter16 - round-robin arbiter in front of the shared 16-bit gate datapath.
//
// Up to N requesters each present a request bit and a W-bit word. One owner is
// granted at a time. The owner's word is registered onto out_y, and priority
// rotates from the last owner so that no requester starves.
//
// Ports:
//   in_clk     clock, rising edge
//   in_reset   synchronous active-high reset
//   in_req     [0:N-1]    request per requester (bit i = requester i)
//   in_data    [0:N*W-1]  packed words, requester i at [i*W : i*W+W-1], MSB first
//   out_gnt    [0:N-1]    registered one-hot grant, or all zeros
//   out_y      [0:W-1]    registered word of the requester granted last cycle
//   out_valid  qualifies out_y
//
// Optional feature: define ARBITER16_BURST_LIMIT_EN to force the owner off the
// bus after MAX_BURST consecutive grant cycles, if another requester is waiting.

module _arbiter16 #(
    parameter int N         = 4,
    parameter int W         = 16,
    parameter int MAX_BURST = 4
) (
    input  logic           in_clk,
    input  logic           in_reset,
    input  logic [0:N-1]   in_req,
    input  logic [0:N*W-1] in_data,
    output logic [0:N-1]   out_gnt,
    output logic [0:W-1]   out_y,
    output logic           out_valid
);

    localparam int LW = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // A bad MAX_BURST is an elaboration error rather than silent misbehaviour.
    generate
        if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
            $error("_arbiter16: MAX_BURST must be in 1..15");
        end
    endgenerate

    logic [0:0]    state_q, state_d;
    logic [LW-1:0] last_q,  last_d;
    logic [0:N-1]  gnt_q,   gnt_d;
    logic [0:W-1]  y_q,     y_d;
    logic          valid_q, valid_d;

`ifdef ARBITER16_BURST_LIMIT_EN
    logic [3:0]    cnt_q,   cnt_d;
    logic          others_pend;
`endif

    logic [LW-1:0] start;
    logic          found;
    logic [LW-1:0] win;
    logic          force_rel;
    int            idx;

    // Round-robin search: first set request from last+1, wrapping modulo N.
    // In GRANT the owner is last_q, so a handover search starts at g+1 and the
    // owner itself is reached last, after every other requester.
    always_comb begin
        start = (last_q == LW'(N - 1)) ? '0 : last_q + 1'b1;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(start) + k;
            if (idx >= N) idx = idx - N;
            if (!found && in_req[idx]) begin
                found = 1'b1;
                win   = LW'(idx);
            end
        end
    end

`ifdef ARBITER16_BURST_LIMIT_EN
    // In GRANT, gnt_q is one-hot on the owner, so masking it leaves the others.
    // Compare with >= so that a counter that ran past the limit while the
    // owner was alone still forces release once someone else shows up.
    always_comb begin
        others_pend = |(in_req & ~gnt_q);
        force_rel   = (cnt_q >= 4'(MAX_BURST)) && others_pend;
    end
`else
    assign force_rel = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
`ifdef ARBITER16_BURST_LIMIT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d     = ST_GRANT;
                    last_d      = win;
                    gnt_d       = '0;
                    gnt_d[win]  = 1'b1;
`ifdef ARBITER16_BURST_LIMIT_EN
                    cnt_d       = 4'd1;
`endif
                end
            end
            default: begin
                if (in_req[last_q] && !force_rel) begin
`ifdef ARBITER16_BURST_LIMIT_EN
                    cnt_d = (cnt_q == 4'd15) ? cnt_q : cnt_q + 4'd1;
`endif
                end else if (found) begin
                    // Direct handover, no idle cycle between owners.
                    last_d      = win;
                    gnt_d       = '0;
                    gnt_d[win]  = 1'b1;
`ifdef ARBITER16_BURST_LIMIT_EN
                    cnt_d       = 4'd1;
`endif
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end
            end
        endcase
    end

    // Capture a word only when its requester holds both grant and request.
    always_comb begin
        valid_d = |(gnt_q & in_req);
        y_d     = y_q;
        for (int i = 0; i < N; i++) begin
            if (gnt_q[i] && in_req[i]) y_d = in_data[i*W +: W];
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            state_q <= ST_IDLE;
            last_q  <= LW'(N - 1);
            gnt_q   <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
`ifdef ARBITER16_BURST_LIMIT_EN
            cnt_q   <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            y_q     <= y_d;
            valid_q <= valid_d;
`ifdef ARBITER16_BURST_LIMIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign out_gnt   = gnt_q;
    assign out_y     = y_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb__arbiter16.sv
// Directed bench for _arbiter16 (N=4, W=16, MAX_BURST=4). Request and grant
// vectors are built by requester index so bit i always means requester i.

module tb__arbiter16;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [0:N-1]   req;
    logic [0:N*W-1] data;
    logic [0:N-1]   gnt;
    logic [0:W-1]   y;
    logic           valid;

    int n_cmp = 0;
    int n_err = 0;

    _arbiter16 #(.N(N), .W(W), .MAX_BURST(4)) dut (
        .in_clk   (clk),
        .in_reset (rst),
        .in_req   (req),
        .in_data  (data),
        .out_gnt  (gnt),
        .out_y    (y),
        .out_valid(valid)
    );

    always #5 clk = ~clk;

    function automatic logic [0:N-1] oh(input int i);
        logic [0:N-1] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic set_word(input int i, input logic [15:0] w);
        data[i*W +: W] = w;
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [0:N-1] eg,
                           input logic ev, input logic [15:0] ey);
        chk({tag, ".gnt"},   32'(gnt),   32'(eg));
        chk({tag, ".valid"}, 32'(valid), 32'(ev));
        chk({tag, ".y"},     32'(y),     32'(ey));
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'b1111;
        data = '0;
        set_word(0, 16'h1111);
        set_word(1, 16'h2222);
        set_word(2, 16'h3333);
        set_word(3, 16'h4444);

        // Reset held with all requests up: outputs stay at reset values.
        for (int c = 0; c < 3; c++) begin
            step();
            chk_out("reset", 4'b0000, 1'b0, 16'h0000);
        end

        // Rotation 0,1,2,3,0 with each owner holding two cycles.
        rst = 1'b0;
        step();
        chk_out("first_grant", oh(0), 1'b0, 16'h0000);
        for (int r = 0; r < 4; r++) begin
            logic [15:0] w;
            w = 16'(16'h1111 * (r + 1));
            step();
            chk_out($sformatf("rot%0d_hold", r), oh(r), 1'b1, w);
            req[r] = 1'b0;
            step();
            chk_out($sformatf("rot%0d_handover", r), oh((r + 1) % 4), 1'b0, w);
            req[r] = 1'b1;
        end

        // Owner 0 (last=0) drops while requester 3 rises on the same edge.
        req = oh(0);
        step();
        chk_out("solo0_hold", oh(0), 1'b1, 16'h1111);
        req = oh(3);
        step();
        chk_out("drop_rise", oh(3), 1'b0, 16'h1111);
        req = '0;
        step();
        chk_out("to_idle", 4'b0000, 1'b0, 16'h1111);

        // Single requester after a fresh reset: 2-cycle request-to-data.
        rst = 1'b1;
        step();
        chk_out("reset2", 4'b0000, 1'b0, 16'h0000);
        rst = 1'b0;
        set_word(1, 16'hBEEF);
        req = oh(1);
        step();
        chk_out("single_gnt", oh(1), 1'b0, 16'h0000);
        step();
        chk_out("single_data", oh(1), 1'b1, 16'hBEEF);

        // Reset mid-grant discards the word in flight; grant restarts at 0.
        set_word(1, 16'hCAFE);
        rst = 1'b1;
        step();
        chk_out("reset_mid", 4'b0000, 1'b0, 16'h0000);
        rst = 1'b0;
        req = 4'b1111;
        step();
        chk_out("restart", oh(0), 1'b0, 16'h0000);

        // Requesters 0 and 1 held high for 12 edges after a reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = oh(0) | oh(1);
        for (int k = 0; k < 12; k++) begin
            step();
`ifdef ARBITER16_BURST_LIMIT_EN
            chk($sformatf("burst_gnt%0d", k), 32'(gnt), 32'(oh((k / 4) % 2)));
`else
            chk($sformatf("burst_gnt%0d", k), 32'(gnt), 32'(oh(0)));
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
